// File: rtl/stage4_memory_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stage4_memory_lsu : memory-stage load/store unit, one outstanding bus txn  |
// | Optional bus-response watchdog: LSU_TIMEOUT_EN        Rev 1.0             |
// +----------------------------------------------------------------------------+

package tcore_param;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        NO_EXCEPTION       = 3'd0,
        LOAD_MISALIGNED    = 3'd1,
        STORE_MISALIGNED   = 3'd2,
        LOAD_ACCESS_FAULT  = 3'd3,
        STORE_ACCESS_FAULT = 3'd4
    } exc_type_e;
endpackage

module stage4_memory_lsu
    import tcore_param::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic            ld_i,
    input  logic            st_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [XLEN-1:0] rdata_o,
    output exc_type_e       exc_type_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i
);

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_REQ   = 3'd1;
    localparam logic [2:0] C_WAIT  = 3'd2;
    localparam logic [2:0] C_DONE  = 3'd3;
    localparam logic [2:0] C_DRAIN = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [3:0]      be_q, be_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      off_q, off_d;
    logic            uns_q, uns_d;
    exc_type_e       exc_q, exc_d;

    logic            w_go;
    logic            w_is_st;
    logic            w_misal;
    logic            w_expired;
    logic [3:0]      w_be_new;
    logic [XLEN-1:0] w_wdata_new;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load_ext;

    // Qualified by rst_ni so every output is 0 while reset is held, even with a valid request present.
    assign w_go    = rst_ni & valid_i & (ld_i | st_i) & ~flush_i;
    assign w_is_st = st_i & ~ld_i;

    always_comb begin
        w_misal     = 1'b0;
        w_be_new    = 4'b1111;
        w_wdata_new = wdata_i;
        case (size_i)
            2'b00: begin
                w_be_new    = 4'b0001 << addr_i[1:0];
                w_wdata_new = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_misal     = addr_i[0];
                w_be_new    = 4'b0011 << addr_i[1:0];
                w_wdata_new = {2{wdata_i[15:0]}};
            end
            default: w_misal = |addr_i[1:0];
        endcase
    end

    assign w_shifted = mem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   w_load_ext = {{(XLEN-8){w_shifted[7] & ~uns_q}}, w_shifted[7:0]};
            2'b01:   w_load_ext = {{(XLEN-16){w_shifted[15] & ~uns_q}}, w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [C_CNT_W-1:0] cnt_q, cnt_d;

    assign w_expired = (cnt_q == C_CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((state_d != state_q) && ((state_d == C_WAIT) || (state_d == C_DRAIN))) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= C_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
            uns_q   <= 1'b0;
            exc_q   <= NO_EXCEPTION;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        we_d    = we_q;
        size_d  = size_q;
        off_d   = off_q;
        uns_d   = uns_q;
        exc_d   = exc_q;
        case (state_q)
            C_IDLE: begin
                if (w_go && !w_misal) begin
                    state_d = C_REQ;
                    addr_d  = {addr_i[XLEN-1:2], 2'b00};
                    wdata_d = w_wdata_new;
                    be_d    = w_be_new;
                    we_d    = w_is_st;
                    size_d  = size_i;
                    off_d   = addr_i[1:0];
                    uns_d   = unsigned_i;
                    rdata_d = '0;
                    exc_d   = NO_EXCEPTION;
                end
            end
            C_REQ: begin
                if (mem_gnt_i) begin
                    state_d = flush_i ? C_DRAIN : C_WAIT;
                end else if (flush_i) begin
                    state_d = C_IDLE;
                end
            end
            C_WAIT: begin
                // A response arriving with the flush already closes the transaction.
                if (mem_rvalid_i) begin
                    if (flush_i) begin
                        state_d = C_IDLE;
                    end else begin
                        state_d = C_DONE;
                        if (!we_q) begin
                            rdata_d = w_load_ext;
                        end
                        if (mem_err_i) begin
                            exc_d = we_q ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT;
                        end
                    end
                end else if (flush_i) begin
                    state_d = C_DRAIN;
                end else if (w_expired) begin
                    state_d = C_DONE;
                    rdata_d = '0;
                    exc_d   = we_q ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT;
                end
            end
            C_DONE: state_d = C_IDLE;
            C_DRAIN: begin
                if (mem_rvalid_i || w_expired) begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        stall_o     = 1'b0;
        rdata_o     = '0;
        exc_type_o  = NO_EXCEPTION;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        case (state_q)
            C_IDLE: begin
                if (w_go) begin
                    if (w_misal) begin
                        exc_type_o = w_is_st ? STORE_MISALIGNED : LOAD_MISALIGNED;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
            end
            C_REQ: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = addr_q;
                mem_be_o    = be_q;
                mem_wdata_o = wdata_q;
            end
            C_WAIT: stall_o = 1'b1;
            C_DONE: begin
                rdata_o    = rdata_q;
                exc_type_o = exc_q;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_stage4_memory_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_stage4_memory_lsu : self-checking bench for stage4_memory_lsu           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

module tb_stage4_memory_lsu;
    import tcore_param::*;

    logic        clk_i, rst_ni;
    logic        valid_i, ld_i, st_i, unsigned_i, flush_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    exc_type_e   exc_type_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    stage4_memory_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ld_i(ld_i), .st_i(st_i),
        .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .flush_i(flush_i), .stall_o(stall_o), .rdata_o(rdata_o), .exc_type_o(exc_type_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int n;
        n = nbytes(sz);
        if (n == 4) return 4'hF;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        case (nbytes(sz))
            1:       return (w % 256) * 32'h0101_0101;
            2:       return (w % 65536) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] sz,
                                           input logic [31:0] a, input logic uns);
        longint v;
        int     n;
        n = nbytes(sz);
        if (n == 4) return rd;
        v = longint'(rd) >> (8 * (a % 4));
        v = v % (longint'(1) << (8 * n));
        if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic drive_req(input logic is_ld, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] w);
        valid_i = 1'b1; ld_i = is_ld; st_i = ~is_ld; size_i = sz;
        unsigned_i = uns; addr_i = a; wdata_i = w; flush_i = 1'b0;
    endtask

    // Full transaction with bus delays; stray rvalid injected where it must be ignored.
    task automatic do_txn(input string tag, input logic is_ld, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] w,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                          input logic err);
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0]  e_be;
        exc_type_e   e_exc;
        e_addr = a - (a % 4);
        e_be   = m_be(sz, a);
        e_wd   = m_wdata(sz, w);
        e_rd   = is_ld ? m_load(rd, sz, a, uns) : 32'h0;
        e_exc  = err ? (is_ld ? LOAD_ACCESS_FAULT : STORE_ACCESS_FAULT) : NO_EXCEPTION;

        @(negedge clk_i);
        drive_req(is_ld, sz, uns, a, w);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
        #1;
        n_tests++;
        if (stall_o !== 1'b1 || mem_req_o !== 1'b0 || exc_type_o !== NO_EXCEPTION) begin
            n_fail++;
            $display("FAIL %s accept: stall=%b req=%b exc=%0d, want stall=1 req=0 exc=0",
                     tag, stall_o, mem_req_o, exc_type_o);
        end
        for (int k = 0; k <= gnt_dly; k++) begin
            @(negedge clk_i);
            mem_gnt_i    = (k == gnt_dly);
            mem_rvalid_i = (k < gnt_dly) ? 1'($urandom % 2) : 1'b0;
            mem_rdata_i  = $urandom;
            mem_err_i    = 1'($urandom % 2);
            #1;
            n_tests++;
            if (mem_req_o !== 1'b1 || mem_we_o !== ~is_ld || mem_addr_o !== e_addr ||
                mem_be_o !== e_be || mem_wdata_o !== e_wd || stall_o !== 1'b1 || rdata_o !== 32'h0) begin
                n_fail++;
                $display("FAIL %s req[%0d]: req=%b we=%b addr=%h be=%b wd=%h stall=%b, want 1 %b %h %b %h 1",
                         tag, k, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, stall_o,
                         ~is_ld, e_addr, e_be, e_wd);
            end
        end
        for (int k = 0; k <= rv_dly; k++) begin
            @(negedge clk_i);
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = (k == rv_dly);
            mem_rdata_i  = (k == rv_dly) ? rd : $urandom;
            mem_err_i    = (k == rv_dly) ? err : 1'($urandom % 2);
            #1;
            n_tests++;
            if (stall_o !== 1'b1 || mem_req_o !== 1'b0 || rdata_o !== 32'h0 || exc_type_o !== NO_EXCEPTION) begin
                n_fail++;
                $display("FAIL %s wait[%0d]: stall=%b req=%b rdata=%h exc=%0d, want 1 0 0 0",
                         tag, k, stall_o, mem_req_o, rdata_o, exc_type_o);
            end
        end
        @(negedge clk_i);
        mem_rvalid_i = 1'($urandom % 2);
        mem_rdata_i  = $urandom;
        mem_err_i    = 1'($urandom % 2);
        #1;
        n_tests++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || rdata_o !== e_rd || exc_type_o !== e_exc) begin
            n_fail++;
            $display("FAIL %s done: stall=%b req=%b rdata=%h exc=%0d, want 0 0 %h %0d",
                     tag, stall_o, mem_req_o, rdata_o, exc_type_o, e_rd, e_exc);
        end
    endtask

    task automatic do_misal(input string tag, input logic is_ld, input logic [1:0] sz,
                            input logic [31:0] a);
        exc_type_e e_exc;
        e_exc = is_ld ? LOAD_MISALIGNED : STORE_MISALIGNED;
        @(negedge clk_i);
        drive_req(is_ld, sz, 1'b0, a, $urandom);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        n_tests++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || exc_type_o !== e_exc) begin
            n_fail++;
            $display("FAIL %s misaligned: req=%b stall=%b exc=%0d, want 0 0 %0d",
                     tag, mem_req_o, stall_o, exc_type_o, e_exc);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        n_tests++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || exc_type_o !== NO_EXCEPTION) begin
            n_fail++;
            $display("FAIL %s misaligned-after: req=%b stall=%b exc=%0d, want 0 0 0",
                     tag, mem_req_o, stall_o, exc_type_o);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_ni = 1'b0; valid_i = 1'b0; ld_i = 1'b0; st_i = 1'b0; size_i = 2'b00;
        unsigned_i = 1'b0; addr_i = '0; wdata_i = '0; flush_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        n_tests++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || rdata_o !== 32'h0 ||
            mem_addr_o !== 32'h0 || mem_be_o !== 4'h0 || mem_wdata_o !== 32'h0 || exc_type_o !== NO_EXCEPTION) begin
            n_fail++;
            $display("FAIL reset: stall=%b req=%b we=%b rdata=%h addr=%h be=%b wd=%h exc=%0d, want all 0",
                     stall_o, mem_req_o, mem_we_o, rdata_o, mem_addr_o, mem_be_o, mem_wdata_o, exc_type_o);
        end
    endtask

    task automatic test_directed();
        do_txn("lb_signed", 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 1'b0);
        do_txn("sh", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 0, 0, 32'h0, 1'b0);
        do_misal("lw_misal", 1'b1, 2'b10, 32'h0000_3001);
        do_misal("sh_misal", 1'b0, 2'b01, 32'h0000_3003);
        do_txn("lw_gnt5_err", 1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 5, 0, 32'h1234_5678, 1'b1);
        do_txn("lhu", 1'b1, 2'b01, 1'b1, 32'h0000_5002, 32'h0, 1, 2, 32'h9ABC_0000, 1'b0);
        do_txn("lres", 1'b1, 2'b11, 1'b0, 32'h0000_6004, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b0);
    endtask

    task automatic test_flush_wait();
        @(negedge clk_i);
        drive_req(1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'h0);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0; flush_i = 1'b1;
        #1;
        n_tests++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_wait stall: got %b want 1", stall_o);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            drive_req(1'b1, 2'b10, 1'b0, 32'h0000_8004, 32'h0);
            mem_rvalid_i = (k == 1);
            mem_rdata_i  = 32'hDEAD_BEEF;
            mem_err_i    = 1'b1;
            #1;
            n_tests++;
            if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || rdata_o !== 32'h0 || exc_type_o !== NO_EXCEPTION) begin
                n_fail++;
                $display("FAIL flush_wait drain[%0d]: stall=%b req=%b rdata=%h exc=%0d, want 0 0 0 0",
                         k, stall_o, mem_req_o, rdata_o, exc_type_o);
            end
        end
        do_txn("after_drain", 1'b1, 2'b10, 1'b0, 32'h0000_8004, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0);
    endtask

    task automatic test_flush_req();
        // Flush before grant drops the request.
        @(negedge clk_i);
        drive_req(1'b0, 2'b00, 1'b0, 32'h0000_9001, 32'h55);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        valid_i = 1'b0; flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        n_tests++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_req drop: req=%b stall=%b, want 0 0", mem_req_o, stall_o);
        end
        // Flush with grant in the same cycle drains the response.
        @(negedge clk_i);
        drive_req(1'b1, 2'b00, 1'b0, 32'h0000_A000, 32'h0);
        @(negedge clk_i);
        valid_i = 1'b0; flush_i = 1'b1; mem_gnt_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            drive_req(1'b1, 2'b00, 1'b0, 32'h0000_A001, 32'h0);
            mem_gnt_i = 1'b0; mem_rvalid_i = (k == 1); mem_rdata_i = 32'hFFFF_FFFF;
            #1;
            n_tests++;
            if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || rdata_o !== 32'h0) begin
                n_fail++;
                $display("FAIL flush_gnt drain[%0d]: stall=%b req=%b rdata=%h, want 0 0 0",
                         k, stall_o, mem_req_o, rdata_o);
            end
        end
        do_txn("after_gnt_drain", 1'b1, 2'b00, 1'b1, 32'h0000_A001, 32'h0, 0, 0, 32'h0000_8100, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk_i);
        drive_req(1'b1, 2'b10, 1'b0, 32'h0000_B000, 32'h0);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        #1;
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || rdata_o !== 32'h0 || mem_be_o !== 4'h0 ||
            mem_addr_o !== 32'h0 || exc_type_o !== NO_EXCEPTION) begin
            n_fail++;
            $display("FAIL async_reset: stall=%b req=%b rdata=%h be=%b addr=%h exc=%0d, want all 0",
                     stall_o, mem_req_o, rdata_o, mem_be_o, mem_addr_o, exc_type_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1; valid_i = 1'b0;
        do_txn("after_reset", 1'b0, 2'b10, 1'b0, 32'h0000_B100, 32'h1122_3344, 0, 0, 32'h0, 1'b0);
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk_i);
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_C000, 32'hA5A5_A5A5);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            mem_gnt_i = 1'b0;
            #1;
            n_tests++;
            if (stall_o !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout wait[%0d]: stall=%b want 1", k, stall_o);
            end
        end
        @(negedge clk_i);
        #1;
        n_tests++;
        if (stall_o !== 1'b0 || exc_type_o !== STORE_ACCESS_FAULT || rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout done: stall=%b exc=%0d rdata=%h, want 0 %0d 0",
                     stall_o, exc_type_o, rdata_o, STORE_ACCESS_FAULT);
        end
        @(negedge clk_i);
        valid_i = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b1;
        #1;
        n_tests++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || exc_type_o !== NO_EXCEPTION) begin
            n_fail++;
            $display("FAIL timeout stray: stall=%b req=%b exc=%0d, want 0 0 0", stall_o, mem_req_o, exc_type_o);
        end
        mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [1:0]  sz;
        logic [31:0] a;
        logic        is_ld;
        for (int i = 0; i < 40; i++) begin
            sz    = 2'($urandom % 4);
            a     = $urandom;
            is_ld = 1'($urandom % 2);
            if (i % 3 != 0) a = a - (a % nbytes(sz));
            if (misal(sz, a)) begin
                do_misal("rand_misal", is_ld, sz, a);
            end else begin
                do_txn("rand", is_ld, sz, 1'($urandom % 2), a, $urandom,
                       int'($urandom % 4), int'($urandom % 4), $urandom, ($urandom % 8) == 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            do_txn("b2b", 1'(i % 2), 2'(i % 3), 1'b0, 32'h0000_D000 + 32'(4 * i),
                   $urandom, 0, 0, $urandom, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush_wait();
        test_flush_req();
        test_async_reset();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        test_back_to_back();
        @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stage4_memory_lsu.md
Name: stage4_memory_lsu

Overview:
- Load/store unit of the memory stage; sits directly upstream of the writeback stage.
- Turns a memory-stage load or store into a single-outstanding req/gnt/rvalid transaction on the data bus.
- Holds the pipeline with `stall_o` until the transaction finishes.
- Delivers sign- or zero-extended load data as `rdata_o` (the writeback `read_data` input) and an `exc_type_e` (misaligned/access fault) for trap generation in writeback.

Parameters:
- TIMEOUT_CYCLES, 256: bus-response watchdog limit. Used only with LSU_TIMEOUT_EN.
- XLEN: taken from tcore_param, 32.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  memory-stage instruction valid
- ld_i  in  1  instruction is a load
- st_i  in  1  instruction is a store
- size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- unsigned_i  in  1  zero-extend the load
- addr_i  in  XLEN  effective address (ALU result)
- wdata_i  in  XLEN  store data (rs2)
- flush_i  in  1  kill the current memory-stage instruction
- stall_o  out  1  hold the pipeline
- rdata_o  out  XLEN  extended load data
- exc_type_o  out  exc_type_e  NO_EXCEPTION / LOAD_MISALIGNED / STORE_MISALIGNED / LOAD_ACCESS_FAULT / STORE_ACCESS_FAULT
- mem_req_o  out  1  bus request
- mem_we_o  out  1  write
- mem_addr_o  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  XLEN  lane-replicated store data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response valid
- mem_rdata_i  in  XLEN  response data
- mem_err_i  in  1  response error, qualified by rvalid

Behaviour:
- Reset: state IDLE. All outputs 0 and `exc_type_o`=NO_EXCEPTION. Any outstanding transaction is forgotten.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE, with `valid_i`&(`ld_i`|`st_i`)&!`flush_i`:
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus request, `stall_o`=0, and `exc_type_o`=LOAD_/STORE_MISALIGNED combinationally that cycle. Stay IDLE.
  - Aligned: `stall_o`=1. Register addr, we, be, wdata, size, unsigned and offset. Go to REQ.
- Byte enables: byte 0001<<off, half 0011<<off, word 1111.
- `mem_wdata_o`: byte replicated x4, half replicated x2, word as is.
- REQ: `mem_req_o`=1 with registered fields held stable. `stall_o`=1. On `mem_gnt_i` go to WAIT; with no gnt, hold indefinitely.
- WAIT: `stall_o`=1. On `mem_rvalid_i`:
  - Load: shift `mem_rdata_i` right by 8*off, extend per size/unsigned, register into `rdata_q`.
  - On `mem_err_i`: register ACCESS_FAULT (load/store).
  - Go to DONE.
- DONE (exactly one cycle):
  - `stall_o`=0, `rdata_o`=`rdata_q`, `exc_type_o`=registered value.
  - `valid_i` is ignored this cycle (same instruction retiring). Next state IDLE.
- `rdata_o` is 0 outside DONE for stores.
- Minimum load/store latency: 4 cycles (accept, gnt, rvalid, DONE).
- Flush:
  - IDLE: blocks acceptance.
  - REQ before gnt: drop the request, go to IDLE next cycle.
  - REQ with gnt in the same cycle, or WAIT: go to DRAIN. DRAIN waits for rvalid, discards data and error, then goes to IDLE. `stall_o`=0 throughout DRAIN.
  - A new request is not issued until DRAIN exits.
- `mem_rvalid_i` in IDLE/REQ/DONE is ignored.
- Reserved size 11 uses word alignment and byte enables.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES-1 without rvalid: go to DONE with LOAD_/STORE_ACCESS_FAULT and `rdata_q`=0.
  - A later stray rvalid is ignored.
  - The counter also applies in DRAIN and forces IDLE on expiry.
- Undefined: no counter; WAIT/DRAIN wait indefinitely.

Test Plan:
- LB, addr 0x1003, unsigned=0, rdata 0x80FF_1234 -> be 1000; DONE `rdata_o`=0xFFFF_FF80; `stall_o` high 3 cycles.
- SH, addr 0x2002, wdata 0x0000_BEEF -> mem_addr 0x2000, be 1100, mem_wdata 0xBEEF_BEEF, NO_EXCEPTION.
- LW, addr 0x3001 -> no `mem_req_o`, `stall_o`=0, `exc_type_o`=LOAD_MISALIGNED same cycle.
- Load with gnt delayed 5 cycles, then rvalid with `mem_err_i`=1 -> `mem_req_o` and fields stable 5 cycles; DONE `exc_type_o`=LOAD_ACCESS_FAULT.
- `flush_i` in WAIT, rvalid 2 cycles later with 0xDEAD_BEEF -> DRAIN, `rdata_o` stays 0, no exception, the next load is accepted only after rvalid.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, no rvalid -> DONE after 8 WAIT cycles with STORE_ACCESS_FAULT for a store; async reset mid-WAIT -> all outputs 0 immediately.
